fb_write_scheduler: RTL

//  Owns the single write port shared by the red/green/blue frame buffers and sequences every write into it.

---
 rtl/fb_write_scheduler_pkg.sv | 20 ++
 rtl/fb_clear_scanner.sv | 53 +++++
 rtl/fb_write_scheduler.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/fb_write_scheduler_pkg.sv
// Shared types and defaults for the frame-buffer write scheduler.
// Holds the FSM state encoding, the requester ids used by the
// round-robin pointer, and the default frame geometry.
package fb_write_scheduler_pkg;

  localparam int COORD_W_DEF = 11;
  localparam int W_RES_DEF   = 640;
  localparam int H_RES_DEF   = 480;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_t;

endpackage

// File: rtl/fb_clear_scanner.sv
// Raster scanner for the full-frame clear.
// x/y is the pixel to be written in the current clear cycle.
// start : the origin (0,0) is being written now; advance past it.
// step  : the current pixel is being written; advance (x fastest,
//         wrapping W_RES-1 -> 0 and bumping y; wraps to origin at the end).
// last  : current pixel is (W_RES-1, H_RES-1).
// Ports: clock, reset (sync, active-high), start, step, x, y, last.
module fb_clear_scanner
  import fb_write_scheduler_pkg::*;
#(
  parameter int W_RES   = W_RES_DEF,
  parameter int H_RES   = H_RES_DEF,
  parameter int COORD_W = COORD_W_DEF
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic               step,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic               last
);

  localparam logic [COORD_W-1:0] X_MAX = COORD_W'(W_RES - 1);
  localparam logic [COORD_W-1:0] Y_MAX = COORD_W'(H_RES - 1);

  logic [COORD_W-1:0] base_x, base_y, nxt_x, nxt_y;

  always_comb begin
    base_x = start ? '0 : x;
    base_y = start ? '0 : y;
    if (base_x == X_MAX) begin
      nxt_x = '0;
      nxt_y = (base_y == Y_MAX) ? '0 : base_y + 1'b1;
    end else begin
      nxt_x = base_x + 1'b1;
      nxt_y = base_y;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      x <= '0;
      y <= '0;
    end else if (start || step) begin
      x <= nxt_x;
      y <= nxt_y;
    end
  end

  assign last = (x == X_MAX) && (y == Y_MAX);

endmodule

// File: rtl/fb_write_scheduler.sv
// Owner of the single shared write port into the R/G/B frame buffers.
// Sequences full-frame clears and arbitrates (round-robin) between two
// pixel requesters A and B; at most one pixel write per cycle.
// Ports:
//   clock, reset                : clock, synchronous active-high reset
//   clear_start                 : 1-cycle pulse starting a full-frame clear
//   clear_busy, clear_done      : clear write in progress / last clear write
//   a_* / b_*                   : valid/ready requesters with x, y, r, g, b
//   wr_en, wr_x, wr_y, wr_r/g/b : registered buffer write port
//   drop                        : accepted pixel was out of range, not written
module fb_write_scheduler
  import fb_write_scheduler_pkg::*;
#(
  parameter int         W_RES   = W_RES_DEF,
  parameter int         H_RES   = H_RES_DEF,
  parameter int         COORD_W = COORD_W_DEF,
  parameter logic [7:0] CLR_R   = 8'd0,
  parameter logic [7:0] CLR_G   = 8'd0,
  parameter logic [7:0] CLR_B   = 8'd0
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               clear_start,
  output logic               clear_busy,
  output logic               clear_done,
  input  logic               a_valid,
  output logic               a_ready,
  input  logic [COORD_W-1:0] a_x,
  input  logic [COORD_W-1:0] a_y,
  input  logic [7:0]         a_r,
  input  logic [7:0]         a_g,
  input  logic [7:0]         a_b,
  input  logic               b_valid,
  output logic               b_ready,
  input  logic [COORD_W-1:0] b_x,
  input  logic [COORD_W-1:0] b_y,
  input  logic [7:0]         b_r,
  input  logic [7:0]         b_g,
  input  logic [7:0]         b_b,
  output logic               wr_en,
  output logic [COORD_W-1:0] wr_x,
  output logic [COORD_W-1:0] wr_y,
  output logic [7:0]         wr_r,
  output logic [7:0]         wr_g,
  output logic [7:0]         wr_b,
  output logic               drop
);

  localparam logic [COORD_W-1:0] X_MAX     = COORD_W'(W_RES - 1);
  localparam logic [COORD_W-1:0] Y_MAX     = COORD_W'(H_RES - 1);
  localparam bit                 ONE_PIXEL = (W_RES == 1) && (H_RES == 1);

  state_t             state, state_nxt;
  req_t               prio;
  logic               scan_start, scan_step, scan_last;
  logic [COORD_W-1:0] scan_x, scan_y;
  logic               clr_wr, clr_last;
  logic [COORD_W-1:0] clr_x, clr_y;
  logic               port_free, accept, in_range;
  logic [COORD_W-1:0] sel_x, sel_y;
  logic [7:0]         sel_r, sel_g, sel_b;

  fb_clear_scanner #(
    .W_RES  (W_RES),
    .H_RES  (H_RES),
    .COORD_W(COORD_W)
  ) u_scanner (
    .clock(clock),
    .reset(reset),
    .start(scan_start),
    .step (scan_step),
    .x    (scan_x),
    .y    (scan_y),
    .last (scan_last)
  );

  // Clear FSM: the origin is issued in the same cycle clear_start is seen,
  // so the first clear pixel appears on the port one cycle later. The cycle
  // that shows the final clear pixel is still busy, so a start there is
  // ignored as well.
  always_comb begin
    state_nxt  = state;
    scan_start = 1'b0;
    scan_step  = 1'b0;
    clr_wr     = 1'b0;
    clr_last   = 1'b0;
    clr_x      = '0;
    clr_y      = '0;
    case (state)
      ST_IDLE: begin
        if (clear_start && !clear_busy) begin
          scan_start = 1'b1;
          clr_wr     = 1'b1;
          clr_last   = ONE_PIXEL;
          state_nxt  = ONE_PIXEL ? ST_IDLE : ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        scan_step = 1'b1;
        clr_wr    = 1'b1;
        clr_x     = scan_x;
        clr_y     = scan_y;
        clr_last  = scan_last;
        if (scan_last) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Round-robin arbiter: prio names the requester served on a tie.
  always_comb begin
    port_free = (state == ST_IDLE) && !clear_busy && !clear_start;
    a_ready   = port_free && a_valid && (!b_valid || prio == REQ_A);
    b_ready   = port_free && b_valid && (!a_valid || prio == REQ_B);
    accept    = a_ready || b_ready;
    sel_x     = b_ready ? b_x : a_x;
    sel_y     = b_ready ? b_y : a_y;
    sel_r     = b_ready ? b_r : a_r;
    sel_g     = b_ready ? b_g : a_g;
    sel_b     = b_ready ? b_b : a_b;
    in_range  = (sel_x <= X_MAX) && (sel_y <= Y_MAX);
  end

  // Output register stage: everything the buffers see is registered here.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= ST_IDLE;
      prio       <= REQ_A;
      wr_en      <= 1'b0;
      wr_x       <= '0;
      wr_y       <= '0;
      wr_r       <= '0;
      wr_g       <= '0;
      wr_b       <= '0;
      drop       <= 1'b0;
      clear_busy <= 1'b0;
      clear_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      wr_en      <= 1'b0;
      drop       <= 1'b0;
      clear_busy <= clr_wr;
      clear_done <= clr_wr && clr_last;
      if (clr_wr) begin
        wr_en <= 1'b1;
        wr_x  <= clr_x;
        wr_y  <= clr_y;
        wr_r  <= CLR_R;
        wr_g  <= CLR_G;
        wr_b  <= CLR_B;
      end else if (accept) begin
        prio <= b_ready ? REQ_A : REQ_B;
        if (in_range) begin
          wr_en <= 1'b1;
          wr_x  <= sel_x;
          wr_y  <= sel_y;
          wr_r  <= sel_r;
          wr_g  <= sel_g;
          wr_b  <= sel_b;
        end else begin
          drop <= 1'b1;
        end
      end
    end
  end

endmodule
